// File: rtl/addsweep_driver.sv
// Self-test front end for the registered 3-bit adder: sweeps all 64 operand pairs,
// tracks adder latency with an expected-value pipeline and reports mismatches.
module addsweep_driver #(
   parameter int unsigned LAT = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       hold,
   input  logic [3:0] c,
   output logic [2:0] a,
   output logic [2:0] b,
   output logic       busy,
   output logic       done,
   output logic [6:0] err_cnt,
   output logic       err_flag,
   output logic [5:0] first_err_idx
);

   localparam int unsigned IDX_W = 6;
   localparam int unsigned SUM_W = 4;
   localparam int unsigned CNT_W = 7;
   localparam logic [IDX_W-1:0] LAST_IDX = '1;

   typedef struct packed {
      logic             valid;
      logic [SUM_W-1:0] exp;
      logic [IDX_W-1:0] idx;
   } entry_t;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t           state;
   logic [IDX_W-1:0] idx_c;
   logic             issue_c;
   logic             cmp_en_c;
   logic             mismatch_c;
   logic             last_cmp_c;
   entry_t           cur_c;
   entry_t           tail_c;

   // Entry for the pair presented this cycle; it enters the pipeline at the next edge.
   always_comb begin
      idx_c     = {a, b};
      issue_c   = (state == RUN) && !hold;
      cur_c.valid = issue_c;
      cur_c.exp   = SUM_W'(a) + SUM_W'(b);
      cur_c.idx   = idx_c;
   end

   // The tail seen at an edge is the entry issued LAT-1 edges earlier; LAT=1 compares on issue.
   generate
      if (LAT == 1) begin : g_direct
         assign tail_c = cur_c;
      end else begin : g_pipe
         entry_t pipe_q [LAT-1];

         always_ff @(posedge clk) begin
            if (!rst_n || (start && (state == IDLE || state == DONE))) begin
               for (int i = 0; i < int'(LAT) - 1; i++) pipe_q[i].valid <= 1'b0;
            end else begin
               pipe_q[0] <= cur_c;
               for (int i = 1; i < int'(LAT) - 1; i++) pipe_q[i] <= pipe_q[i-1];
            end
         end

         assign tail_c = pipe_q[LAT-2];
      end
   endgenerate

   always_comb begin
      cmp_en_c   = tail_c.valid && (state == RUN || state == DRAIN);
      mismatch_c = cmp_en_c && (c != tail_c.exp);
      last_cmp_c = cmp_en_c && (tail_c.idx == LAST_IDX);
   end

   // Sweep sequencer with registered outputs and error bookkeeping.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         a             <= '0;
         b             <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         err_cnt       <= '0;
         err_flag      <= 1'b0;
         first_err_idx <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state         <= RUN;
                  a             <= '0;
                  b             <= '0;
                  busy          <= 1'b1;
                  done          <= 1'b0;
                  err_cnt       <= '0;
                  err_flag      <= 1'b0;
                  first_err_idx <= '0;
               end
            end
            RUN: begin
               if (issue_c && idx_c != LAST_IDX) begin
                  {a, b} <= idx_c + IDX_W'(1);
               end
               if (last_cmp_c) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else if (issue_c && idx_c == LAST_IDX) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (last_cmp_c) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase

         if (mismatch_c) begin
            err_cnt <= err_cnt + CNT_W'(1);
            if (!err_flag) begin
               err_flag      <= 1'b1;
               first_err_idx <= tail_c.idx;
            end
         end
      end
   end

endmodule

// File: doc/addsweep_driver.md
# addsweep_driver

Exhaustive stimulus and checking stage sitting directly upstream of the registered 3-bit adder stage (a, b -> 4-bit c). On a start request it sweeps all 64 operand pairs into the adder, one per cycle. It tracks the adder latency with an expected-value pipeline, compares every returned sum, and reports an error count plus the first failing pair. It is used as the self-test front end for the adder in the counter datapath.

## Interface
- LAT, 1: adder latency in clock edges from a/b change to c update; legal 1..4.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock; synchronous, active-low.
- start  in  1  begin a sweep; sampled in IDLE and DONE only.
- hold  in  1  freeze operand issue while high.
- c  in  4  sum returned by the adder stage.
- a  out  3  operand A to adder; registered.
- b  out  3  operand B to adder; registered.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE; held until next start or reset.
- err_cnt  out  7  number of mismatching pairs in the last sweep (0..64).
- err_flag  out  1  sticky: at least one mismatch in the last sweep.
- first_err_idx  out  6  index {a,b} of the first mismatch; 0 if none.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- Pair index idx = {a,b} (6 bits); b is the inner digit, a the outer; idx runs 0..63.
- IDLE/DONE + start=1: clear err_cnt, err_flag, first_err_idx, and the pipeline; a=0, b=0; go to RUN.
- RUN, hold=0: current pair counts as issued. Push {valid=1, exp=a+b (4-bit, zero-extended)} into the LAT-deep expected pipeline. Increment idx. If idx==63, keep a=b=7 and go to DRAIN.
- RUN, hold=1: a/b unchanged, push valid=0, no issue.
- DRAIN: push valid=0 each cycle, a/b stay 7/7. Leave for DONE on the edge at which the last valid entry is compared.
- Compare: on each edge where the pipeline tail is valid, c != exp -> err_cnt+1. If err_flag was 0, set err_flag and latch first_err_idx = tail's idx. Pipeline entries carry idx.
- start while busy ignored; hold outside RUN ignored.
- err_cnt cannot exceed 64; no saturation logic needed, no wrap.

## Timing
- Reset (rst_n low at an edge): state IDLE; a=0, b=0, busy=0, done=0, err_cnt=0, err_flag=0, first_err_idx=0; pipeline valids cleared. Applies mid-sweep with no completion reporting.
- Call E0 the edge sampling start in IDLE. Pair k is presented on a/b during the cycle after edge Ek, with no holds.
- Pair k's sum is compared at edge E(k+LAT).
- Last comparison is at E(63+LAT). done=1 and busy=0 are visible after that edge. With LAT=1, DRAIN lasts 0 cycles and RUN goes straight to DONE at E64.
- Each cycle with hold=1 in RUN delays every subsequent issue, compare, and done by one cycle.
- busy rises after E0 and falls in the same cycle done rises. err_cnt/first_err_idx are final when done rises.
- Restart from DONE: done drops after the start edge; outputs clear on that same edge.

## Test plan
- Correct adder model (LAT=1), start pulse at E0 -> 64 pairs (0,0)..(7,7) in order; done after E64; err_cnt=0, err_flag=0.
- Adder model with c[0] stuck at 0 -> err_cnt=32, err_flag=1, first_err_idx=1 (a=0, b=1).
- hold high for 5 cycles after pair 20 is presented -> a/b frozen at (2,4) for 5 cycles; done after E69; err_cnt=0.
- rst_n low for one edge mid-sweep at idx=30 -> IDLE next cycle, a=b=0, busy=0, done=0; a new start gives a full clean sweep.
- LAT=3 with a matching 3-stage adder model -> done after E66, err_cnt=0. The same model with LAT=1 configured -> err_cnt nonzero.
- start pulsed again at idx=10 during RUN -> ignored, sweep completes normally. start in DONE -> counters cleared, second sweep identical.
